vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Downstream display stage for the OV7670 capture path on the Nexys4.
- Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock.
- Reads RGB332 pixels from the dual-port frame buffer that capture writes.
- Scales the 160x120 stored image by SCALE, expands each pixel to the board's 4:4:4 VGA pins, and blanks everything outside the image.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- IMG_W, 160, stored image width in pixels
- IMG_H, 120, stored image height in pixels
- SCALE, 4, integer replication factor per axis; IMG_W*SCALE<=H_VISIBLE and IMG_H*SCALE<=V_VISIBLE
- ADDR_W, 15, frame buffer address width; 2^ADDR_W>=IMG_W*IMG_H

Ports:
- Clk  in  1  25 MHz pixel clock; all logic on rising edge
- Rst  in  1  asynchronous reset, active-high
- rd_addr  out  ADDR_W  frame buffer read address
- rd_data  in  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}, valid 1 cycle after rd_addr (synchronous read)
- VGA_Hsync  out  1  horizontal sync, active-low
- VGA_Vsync  out  1  vertical sync, active-low
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0) on the pins

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL=800.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL=525. It increments when h_cnt wraps to 0.
  - Both wrap to 0 together at (799,524).
- Reset (async assert, sync release):
  - h_cnt=0, v_cnt=0, rd_addr=0.
  - VGA_Hsync=1, VGA_Vsync=1.
  - VGA_R/G/B=0, frame_start=0.
  - All pipeline registers are cleared.
  - Reset mid-line or mid-frame restarts at (0,0) with no partial sync pulse carried over.
- Pipeline, stage 0 (cycle n): counters at (h,v).
  - in_img = h<IMG_W*SCALE && v<IMG_H*SCALE.
  - rd_addr = (v/SCALE)*IMG_W + h/SCALE when in_img, else 0.
  - rd_addr is driven combinationally from registered counter state.
- Pipeline, stage 1 (cycle n+1): rd_data is valid. Delayed in_img, sync and blank flags are held in stage-1 registers.
- Pipeline, stage 2 (cycle n+2): all VGA pins and frame_start update from the stage-1 registers. Total latency from counter to pins is 2 clocks for every signal, so syncs stay aligned with colour.
- Address generation:
  - No multiplier.
  - A horizontal sub-counter advances the column every SCALE clocks.
  - Row base advances by IMG_W every SCALE lines and resets to 0 at v_cnt=0.
  - Must equal the formula above for all (h,v).
- Sync pulses (in stage-0 terms; appear 2 clocks later on pins):
  - Hsync low for h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751].
  - Vsync low for v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [490,491], over full lines.
- Colour expansion, when in_img and visible:
  - R = {r[2:0], r[2]}
  - G = {g[2:0], g[2]}
  - B = {b[1:0], b[1:0]}
- Colour outside the image or during blanking: R=G=B=0 regardless of rd_data.
- frame_start: asserted on pins exactly for the clock in which pixel (0,0) is presented.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_*, V_*, H_TOTAL, V_TOTAL);
  - the RGB332 field positions;
  - an expansion function rgb332_to_444.
- One natural sub-module: vga_timing. It contains the h/v counters and raw sync/visible flags at stage 0.
- vga_frame_reader adds address generation, the 2-stage pipeline and colour output.

Test Plan:
- Reset, then run: VGA_Hsync=1, VGA_Vsync=1, RGB=0 while Rst=1. First Hsync low edge occurs 656+2 clocks after release; pulse width is 96 clocks; period is 800.
- Full frame: Vsync low for exactly 2*800 clocks starting at line 490 (+2 clocks). Frame period is 420000 clocks. frame_start pulses once per frame.
- Address sweep: (h,v)=(0,0)->0, (4,0)->1, (3,3)->0, (0,4)->160, (639,479)->19199. Outside the image (rd_addr) = 0.
- Colour: rd_data=8'hE0 -> R=F,G=0,B=0. 8'h1C -> R=0,G=F,B=0. 8'h03 -> R=0,G=0,B=F. 8'h49 -> R=4 (r=010 -> 0100), G=4 (g=010 -> 0100), B=5 (b=01 -> 0101). All appear 2 clocks after the address.
- Blanking: hold rd_data=8'hFF constantly. RGB=0 for h>=640 or v>=480 (stage-0 terms), and F/F/F inside.
- Reset asserted at h=300, v=200: outputs go to reset values immediately (async). After release, counting resumes from (0,0) and the next frame_start arrives 2 clocks later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants, RGB332 field layout and the 332 -> 444 colour expansion.
package vga_pkg;

    // 640x480@60 Hz timing, 25 MHz pixel clock
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Stored image geometry and frame buffer address width
    localparam int IMG_W  = 160;
    localparam int IMG_H  = 120;
    localparam int SCALE  = 4;
    localparam int ADDR_W = 15;

    // RGB332 pixel layout {R[2:0],G[2:0],B[1:0]}
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Widen each channel by repeating its top bits so full scale maps to 4'hF
    function automatic rgb444_t rgb332_to_444(input logic [7:0] pix);
        rgb444_t    c;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r   = pix[R_MSB:R_LSB];
        g   = pix[G_MSB:G_LSB];
        b   = pix[B_MSB:B_LSB];
        c.r = {r, r[2]};
        c.g = {g, g[2]};
        c.b = {b, b};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with raw (stage-0) sync and visible flags.
module vga_timing #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter int H_CW      = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP),
    parameter int V_CW      = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [H_CW-1:0] o_h_cnt,
    output logic [V_CW-1:0] o_v_cnt,
    output logic            o_line_end,
    output logic            o_frame_end,
    output logic            o_origin,
    output logic            o_hsync_act,
    output logic            o_vsync_act,
    output logic            o_visible
);
    import vga_pkg::*;

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CW-1:0] H_LAST    = H_CW'(H_TOT - 1);
    localparam logic [H_CW-1:0] H_VIS_END = H_CW'(H_VISIBLE);
    localparam logic [H_CW-1:0] HS_START  = H_CW'(H_VISIBLE + H_FP);
    localparam logic [H_CW-1:0] HS_STOP   = H_CW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [V_CW-1:0] V_LAST    = V_CW'(V_TOT - 1);
    localparam logic [V_CW-1:0] V_VIS_END = V_CW'(V_VISIBLE);
    localparam logic [V_CW-1:0] VS_START  = V_CW'(V_VISIBLE + V_FP);
    localparam logic [V_CW-1:0] VS_STOP   = V_CW'(V_VISIBLE + V_FP + V_SYNC);

    logic [H_CW-1:0] r_h_cnt;
    logic [V_CW-1:0] r_v_cnt;
    logic            w_h_last;
    logic            w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Pixel counter wraps each line; line counter steps on that wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_CW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + H_CW'(1);
        end
    end

    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_line_end  = w_h_last;
    assign o_frame_end = w_h_last && w_v_last;
    assign o_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_hsync_act = (r_h_cnt >= HS_START) && (r_h_cnt < HS_STOP);
    assign o_vsync_act = (r_v_cnt >= VS_START) && (r_v_cnt < VS_STOP);
    assign o_visible   = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);

endmodule

// File: rtl/vga_frame_reader.sv
// Reads the scaled RGB332 frame buffer image and drives 4:4:4 VGA pins with
// a 2-clock counter-to-pin pipeline shared by syncs, colour and frame_start.
module vga_frame_reader #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter int IMG_W     = vga_pkg::IMG_W,
    parameter int IMG_H     = vga_pkg::IMG_H,
    parameter int SCALE     = vga_pkg::SCALE,
    parameter int ADDR_W    = vga_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              VGA_Hsync,
    output logic              VGA_Vsync,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              frame_start
);
    import vga_pkg::*;

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_CW  = $clog2(H_TOT);
    localparam int V_CW  = $clog2(V_TOT);
    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SCALE - 1);
    localparam logic [H_CW-1:0]   IMG_H_END = H_CW'(IMG_W * SCALE);
    localparam logic [V_CW-1:0]   IMG_V_END = V_CW'(IMG_H * SCALE);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);

    // Stage 0: raster position and raw flags
    logic [H_CW-1:0] w_h_cnt;
    logic [V_CW-1:0] w_v_cnt;
    logic            w_line_end;
    logic            w_frame_end;
    logic            w_origin;
    logic            w_hsync_act;
    logic            w_vsync_act;
    logic            w_visible;
    logic            w_in_img;

    // Address trackers: column = h/SCALE, row base = (v/SCALE)*IMG_W
    logic [SUB_W-1:0]  r_hsub;
    logic [H_CW-1:0]   r_col;
    logic [SUB_W-1:0]  r_vsub;
    logic [ADDR_W-1:0] r_row_base;

    // Stage 1 flags (rd_data arrives alongside these)
    logic r_s1_in_img;
    logic r_s1_hs;
    logic r_s1_vs;
    logic r_s1_fs;

    // Stage 2 pin registers
    logic    r_hsync;
    logic    r_vsync;
    logic    r_fs;
    rgb444_t r_rgb;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .H_CW      (H_CW),
        .V_CW      (V_CW)
    ) u_timing (
        .i_clk       (Clk),
        .i_rst       (Rst),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_line_end  (w_line_end),
        .o_frame_end (w_frame_end),
        .o_origin    (w_origin),
        .o_hsync_act (w_hsync_act),
        .o_vsync_act (w_vsync_act),
        .o_visible   (w_visible)
    );

    assign w_in_img = w_visible && (w_h_cnt < IMG_H_END) && (w_v_cnt < IMG_V_END);

    // Column advances every SCALE pixels and restarts with each line
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_hsub <= '0;
            r_col  <= '0;
        end else if (w_line_end) begin
            r_hsub <= '0;
            r_col  <= '0;
        end else if (r_hsub == SUB_LAST) begin
            r_hsub <= '0;
            r_col  <= r_col + H_CW'(1);
        end else begin
            r_hsub <= r_hsub + SUB_W'(1);
        end
    end

    // Row base steps by IMG_W every SCALE lines and restarts with each frame
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_vsub     <= '0;
            r_row_base <= '0;
        end else if (w_frame_end) begin
            r_vsub     <= '0;
            r_row_base <= '0;
        end else if (w_line_end) begin
            if (r_vsub == SUB_LAST) begin
                r_vsub     <= '0;
                r_row_base <= r_row_base + ROW_STEP;
            end else begin
                r_vsub <= r_vsub + SUB_W'(1);
            end
        end
    end

    // Outside the image the address parks at 0; colour is blanked downstream anyway
    assign rd_addr = w_in_img ? (r_row_base + ADDR_W'(r_col)) : '0;

    // Stage 1: delay flags one clock to line up with the synchronous RAM read
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_s1_in_img <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_fs     <= 1'b0;
        end else begin
            r_s1_in_img <= w_in_img;
            r_s1_hs     <= w_hsync_act;
            r_s1_vs     <= w_vsync_act;
            r_s1_fs     <= w_origin;
        end
    end

    // Stage 2: register pins; syncs are active-low, colour gated by image window
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_fs    <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hsync <= ~r_s1_hs;
            r_vsync <= ~r_s1_vs;
            r_fs    <= r_s1_fs;
            r_rgb   <= r_s1_in_img ? rgb332_to_444(rd_data) : '0;
        end
    end

    assign VGA_Hsync   = r_hsync;
    assign VGA_Vsync   = r_vsync;
    assign VGA_R       = r_rgb.r;
    assign VGA_G       = r_rgb.g;
    assign VGA_B       = r_rgb.b;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader. Horizontal timing and image width
// are the real 640-wide values; the vertical raster is shortened (24 visible
// lines, 30 total, 20-line image) so two frames fit in a short run.
module tb_vga_frame_reader;

    localparam int HV = 640, HFP = 16, HS = 96, HBP = 48, HT = 800;
    localparam int VV = 24, VFP = 2, VS = 2, VBP = 2, VT = 30;
    localparam int IW = 160, IH = 5, SC = 4, AW = 15;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          VGA_Hsync, VGA_Vsync, frame_start;
    logic [3:0]    VGA_R, VGA_G, VGA_B;

    int checks = 0;
    int errors = 0;
    int t      = 0;    // clocks since reset release (stage-0 cycle index)
    bit live   = 1'b0;

    logic [7:0] dir_tab [4] = '{8'hE0, 8'h1C, 8'h03, 8'h49};

    vga_frame_reader #(
        .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .IMG_W (IW), .IMG_H (IH), .SCALE (SC), .ADDR_W (AW)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .VGA_Hsync   (VGA_Hsync),
        .VGA_Vsync   (VGA_Vsync),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .frame_start (frame_start)
    );

    always #20 Clk = ~Clk;

    // ---------------- reference model (raster position from elapsed clocks) ----
    function automatic int m_h(input int s); return s % HT; endfunction
    function automatic int m_v(input int s); return (s / HT) % VT; endfunction
    function automatic bit m_img(input int s);
        return (m_h(s) < IW * SC) && (m_v(s) < IH * SC);
    endfunction
    function automatic int m_addr(input int s);
        return m_img(s) ? (m_v(s) / SC) * IW + m_h(s) / SC : 0;
    endfunction
    // Contents the bench's frame buffer returns for the address of stage-0 cycle s
    function automatic logic [7:0] m_data(input int s);
        int a;
        if (m_v(s) == 2 && m_h(s) >= 100 && m_h(s) <= 103) return dir_tab[m_h(s) - 100];
        if (s >= HT * VT || m_v(s) >= 16) return 8'hFF;
        a = m_addr(s);
        return 8'(((a * 37) ^ (a >> 7)) ^ 8'h5A);
    endfunction

    // ---------------- per-cycle compare against the model ----------------------
    always @(negedge Clk) begin
        logic [AW-1:0] e_addr;
        logic          e_hs, e_vs, e_fs;
        logic [3:0]    e_r, e_g, e_b;
        int            s, h, v, rr, gg, bb;
        logic [7:0]    d;
        if (Rst || live) begin
            e_addr = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
            e_r = '0; e_g = '0; e_b = '0;
            if (!Rst) begin
                e_addr = AW'(m_addr(t));
                if (t >= 2) begin
                    s = t - 2; h = m_h(s); v = m_v(s);
                    e_hs = !(h >= HV + HFP && h < HV + HFP + HS);
                    e_vs = !(v >= VV + VFP && v < VV + VFP + VS);
                    e_fs = (h == 0 && v == 0);
                    if (m_img(s)) begin
                        d  = m_data(s);
                        rr = int'(d[7:5]); gg = int'(d[4:2]); bb = int'(d[1:0]);
                        e_r = 4'(rr * 2 + rr / 4);
                        e_g = 4'(gg * 2 + gg / 4);
                        e_b = 4'(bb * 5);
                    end
                end
            end
            checks++;
            if ({rd_addr, VGA_Hsync, VGA_Vsync, VGA_R, VGA_G, VGA_B, frame_start} !==
                {e_addr, e_hs, e_vs, e_r, e_g, e_b, e_fs}) begin
                errors++;
                if (errors <= 30)
                    $display("FAIL cycle t=%0d rst=%0b got addr=%0d hs=%0b vs=%0b rgb=%h%h%h fs=%0b required addr=%0d hs=%0b vs=%0b rgb=%h%h%h fs=%0b",
                             t, Rst, rd_addr, VGA_Hsync, VGA_Vsync, VGA_R, VGA_G, VGA_B, frame_start,
                             e_addr, e_hs, e_vs, e_r, e_g, e_b, e_fs);
            end
        end
    end

    // ---------------- hand-computed literal checks ------------------------------
    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0d got %0d required %0d", name, t, got, want);
        end else begin
            $display("check %s t=%0d value %0d ok", name, t, got);
        end
    endtask

    // Advance to stage-0 cycle 'target', acting as the synchronous-read RAM
    task automatic run_to(input int target);
        while (t < target) begin
            @(posedge Clk);
            t = t + 1;
            #1 rd_data = m_data(t - 1);
        end
        #4;
    endtask

    task automatic lit_rgb(input string name, input int want);
        lit(name, int'({VGA_R, VGA_G, VGA_B}), want);
    endtask

    initial begin
        Rst = 1'b0; rd_data = 8'h00;
        #5 Rst = 1'b1;
        repeat (4) @(posedge Clk);
        #1 lit("rst_hsync", int'(VGA_Hsync), 1);
        lit("rst_vsync", int'(VGA_Vsync), 1);
        lit_rgb("rst_rgb", 0);
        #9 Rst = 1'b0; t = 0; live = 1'b1;
        #5 lit("addr_0_0", int'(rd_addr), 0);
        run_to(2);     lit("fs_first", int'(frame_start), 1);
        run_to(3);     lit("fs_off", int'(frame_start), 0);
        run_to(4);     lit("addr_4_0", int'(rd_addr), 1);
        run_to(640);   lit("addr_out_h", int'(rd_addr), 0);
        run_to(657);   lit("hs_before", int'(VGA_Hsync), 1);
        run_to(658);   lit("hs_fall", int'(VGA_Hsync), 0);
        run_to(753);   lit("hs_last", int'(VGA_Hsync), 0);
        run_to(754);   lit("hs_rise", int'(VGA_Hsync), 1);
        run_to(1458);  lit("hs_period", int'(VGA_Hsync), 0);
        run_to(1702);  lit_rgb("rgb_E0", 12'hF00);
        run_to(1703);  lit_rgb("rgb_1C", 12'h0F0);
        run_to(1704);  lit_rgb("rgb_03", 12'h00F);
        run_to(1705);  lit_rgb("rgb_49", 12'h445);
        run_to(2403);  lit("addr_3_3", int'(rd_addr), 0);
        run_to(3200);  lit("addr_0_4", int'(rd_addr), 160);
        run_to(15839); lit("addr_last", int'(rd_addr), 799);
        run_to(15841); lit_rgb("blank_in", 12'hFFF);
        run_to(15842); lit_rgb("blank_h", 12'h000);
        run_to(16000); lit("addr_out_v", int'(rd_addr), 0);
        run_to(16002); lit_rgb("blank_v", 12'h000);
        run_to(20801); lit("vs_before", int'(VGA_Vsync), 1);
        run_to(20802); lit("vs_fall", int'(VGA_Vsync), 0);
        run_to(22401); lit("vs_last", int'(VGA_Vsync), 0);
        run_to(22402); lit("vs_rise", int'(VGA_Vsync), 1);
        run_to(24001); lit("fs_pre2", int'(frame_start), 0);
        run_to(24002); lit("fs_second", int'(frame_start), 1);
        run_to(24003); lit("fs_post2", int'(frame_start), 0);
        // Mid-frame reset at line 10, pixel 300 of the second frame
        run_to(32300); lit_rgb("pre_rst_rgb", 12'hFFF);
        Rst = 1'b1; live = 1'b0;
        #1 lit_rgb("async_rgb", 0);
        lit("async_addr", int'(rd_addr), 0);
        repeat (3) @(posedge Clk);
        #10 Rst = 1'b0; t = 0; live = 1'b1;
        run_to(1);     lit("fs_resume_pre", int'(frame_start), 0);
        run_to(2);     lit("fs_resume", int'(frame_start), 1);
        run_to(4);     lit("addr_resume", int'(rd_addr), 1);
        run_to(1000);
        live = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
